// File: rtl/regfile_pkg.sv
// Shared constants and FSM state encoding for the register-file dump reader.
// The optional checksum beat is enabled with `define REGDUMP_CHECKSUM_EN;
// S_CSUM is only reachable in that build.
package regfile_pkg;

  localparam int REG_DATA_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_SEND = 3'd2,
    S_DONE = 3'd3,
    S_CSUM = 3'd4
  } state_t;

endpackage

// File: rtl/regdump_out_reg.sv
// Beat holding register for the dump stream. A beat is loaded when the FSM
// captures read data, held unchanged while the sink stalls, and dropped on
// acceptance. Reset and abort both empty it.
module regdump_out_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              ack,
  input  logic [ADDR_W-1:0] load_idx,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  // Load, hold until the handshake, or clear; clear beats load.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset || clear) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_idx   <= load_idx;
      out_data  <= load_data;
      out_last  <= load_last;
    end else if (ack) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_dump_reader.sv
// Sequential register-file dump reader. Walks indices FIRST_IDX..LAST_IDX on
// a spare read port and streams each value as an index-tagged beat over
// valid/ready. Optional feature macro: REGDUMP_CHECKSUM_EN appends one beat
// (out_idx=0) carrying the XOR of all accepted data beats.
module regfile_dump_reader
  import regfile_pkg::*;
#(
  parameter int DATA_W    = REG_DATA_W,
  parameter int ADDR_W    = REG_ADDR_W,
  parameter int FIRST_IDX = 0,
  parameter int LAST_IDX  = NUM_REGS - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_IDX);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_IDX);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic              handshake;
  logic              abort_hit;
  logic              load;
  logic [ADDR_W-1:0] load_idx;
  logic [DATA_W-1:0] load_data;
  logic              load_last;

  assign handshake = out_valid && out_ready;
  // Abort only matters once a dump is running; in IDLE it merely masks start.
  assign abort_hit = abort && (state != S_IDLE);

`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum;

  // Running XOR of accepted beats, restarted with each dump.
  always_ff @(posedge clk) begin
    if (reset) begin
      csum <= '0;
    end else if (state == S_IDLE && start) begin
      csum <= '0;
    end else if (handshake) begin
      csum <= csum ^ out_data;
    end
  end
`endif

  // Select what the beat register loads: read data in READ, checksum in CSUM.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    load      = (state == S_READ);
    load_idx  = idx;
    load_data = rd_data;
`ifdef REGDUMP_CHECKSUM_EN
    load_last = 1'b0;
    if (state == S_CSUM) begin
      load      = 1'b1;
      load_idx  = '0;
      load_data = csum;
      load_last = 1'b1;
    end
`else
    load_last = (idx == LAST_A);
`endif
  end

  // Dump sequencer: abort first, then the per-state transitions.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      idx     <= FIRST_A;
      rd_addr <= FIRST_A;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort_hit) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start && !abort) begin
              idx     <= FIRST_A;
              rd_addr <= FIRST_A;
              busy    <= 1'b1;
              state   <= S_READ;
            end
          end
          S_READ: state <= S_SEND;
          S_SEND: begin
            if (handshake) begin
              if (out_last) begin
                state <= S_DONE;
                done  <= 1'b1;
              end
`ifdef REGDUMP_CHECKSUM_EN
              else if (idx == LAST_A) begin
                state <= S_CSUM;
              end
`endif
              else begin
                // Increment only below LAST_IDX, so idx never wraps.
                idx     <= idx + ADDR_W'(1);
                rd_addr <= idx + ADDR_W'(1);
                state   <= S_READ;
              end
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
`ifdef REGDUMP_CHECKSUM_EN
          S_CSUM: state <= S_SEND;
`endif
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  regdump_out_reg #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .clear     (abort_hit),
    .load      (load),
    .ack       (handshake),
    .load_idx  (load_idx),
    .load_data (load_data),
    .load_last (load_last),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_data  (out_data),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: a full-range instance (0..31) and a
// narrow instance (8..10) share a register-file model. Expected beats are
// queued when a dump starts and compared as the DUT presents them. Honours
// REGDUMP_CHECKSUM_EN when the bench is built with the same define.
module tb_regfile_dump_reader;

`ifdef REGDUMP_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk;
  logic        reset, start, abort, out_ready, sel;
  logic [31:0] regs [32];
  beat_t       exp_q [$];
  int          passed = 0;
  int          total  = 0;

  logic [4:0]  rd_addr_a, rd_addr_b, out_idx_a, out_idx_b;
  logic [31:0] rd_data_a, rd_data_b, out_data_a, out_data_b;
  logic        out_valid_a, out_valid_b, out_last_a, out_last_b;
  logic        busy_a, busy_b, done_a, done_b;

  logic [4:0]  o_rd_addr, o_idx;
  logic [31:0] o_data;
  logic        o_valid, o_last, o_busy, o_done;

  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];

  assign o_rd_addr = sel ? rd_addr_b   : rd_addr_a;
  assign o_idx     = sel ? out_idx_b   : out_idx_a;
  assign o_data    = sel ? out_data_b  : out_data_a;
  assign o_valid   = sel ? out_valid_b : out_valid_a;
  assign o_last    = sel ? out_last_b  : out_last_a;
  assign o_busy    = sel ? busy_b      : busy_a;
  assign o_done    = sel ? done_b      : done_a;

  regfile_dump_reader u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .start     (start && !sel),
    .abort     (abort),
    .rd_addr   (rd_addr_a),
    .rd_data   (rd_data_a),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .out_idx   (out_idx_a),
    .out_data  (out_data_a),
    .out_last  (out_last_a),
    .busy      (busy_a),
    .done      (done_a)
  );

  regfile_dump_reader #(
    .FIRST_IDX (8),
    .LAST_IDX  (10)
  ) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .start     (start && sel),
    .abort     (abort),
    .rd_addr   (rd_addr_b),
    .rd_data   (rd_data_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .out_idx   (out_idx_b),
    .out_data  (out_data_b),
    .out_last  (out_last_b),
    .busy      (busy_b),
    .done      (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
  endtask

  // Queue the beats a complete dump of first..last must produce.
  task automatic push_dump(input int first, input int last);
    logic [31:0] x;
    beat_t       b;
    x = '0;
    for (int i = first; i <= last; i++) begin
      b.idx  = 5'(i);
      b.data = regs[i];
      b.last = (i == last) && !CSUM;
      exp_q.push_back(b);
      x = x ^ regs[i];
    end
    if (CSUM) begin
      b.idx  = 5'd0;
      b.data = x;
      b.last = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  // Pulse start and check the two-cycle latency to the first valid beat.
  task automatic start_dump(input int first);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("lat_read", 64'({o_valid, o_busy, o_rd_addr}), 64'({1'b0, 1'b1, 5'(first)}));
    tick();
    check("lat_valid", 64'(o_valid), 64'(1'b1));
  endtask

  // Consume beats against the scoreboard. Optional events keyed on beat index
  // (-1 disables): stall for stall_len cycles, abort with the handshake,
  // re-pulse start with the handshake, or assert reset while the beat waits.
  task automatic drain(input int stall_idx, input int stall_len, input int abort_idx,
                       input int restart_idx, input int reset_idx, input int first);
    beat_t e;
    int    stalls      = 0;
    bit    was_stalled = 1'b0;
    bit    post_abort  = 1'b0;
    bit    post_last   = 1'b0;
    bit    fin         = 1'b0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (post_abort) begin
        check("abort_idle", 64'({o_valid, o_busy, o_done}), 64'(3'b000));
        exp_q.delete();
        fin = 1'b1;
      end else if (post_last) begin
        check("done_pulse", 64'({o_done, o_busy, o_valid}), 64'(3'b110));
        tick();
        check("done_end", 64'({o_done, o_busy}), 64'(2'b00));
        fin = 1'b1;
      end else begin
        check("done_early", 64'(o_done), 64'(1'b0));
        if (sel) check("rd_range", 64'(o_rd_addr >= 5'd8 && o_rd_addr <= 5'd10), 64'(1'b1));
        if (was_stalled) check("stall_hold", 64'(o_valid), 64'(1'b1));
        was_stalled = 1'b0;
        out_ready   = 1'b1;
        if (o_valid) begin
          if (exp_q.size() == 0) begin
            check("extra_beat", 64'(o_valid), 64'(1'b0));
          end else begin
            e = exp_q[0];
            check("beat", 64'({o_idx, o_data, o_last}), 64'({e.idx, e.data, e.last}));
            if (int'(o_idx) == reset_idx) begin
              reset = 1'b1;
              tick();
              check("reset_vals",
                    64'({o_valid, o_idx, o_data, o_last, o_busy, o_done, o_rd_addr}),
                    64'({1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'(first)}));
              reset = 1'b0;
              exp_q.delete();
              fin = 1'b1;
            end else if (int'(o_idx) == stall_idx && stalls < stall_len) begin
              out_ready   = 1'b0;
              stalls++;
              was_stalled = 1'b1;
            end else begin
              void'(exp_q.pop_front());
              post_last = e.last;
              if (int'(o_idx) == abort_idx) begin
                abort      = 1'b1;
                post_abort = 1'b1;
              end
              if (int'(o_idx) == restart_idx) start = 1'b1;
            end
          end
        end
        if (!fin) begin
          tick();
          start = 1'b0;
          abort = 1'b0;
        end
      end
    end
    check("drain_finished", 64'(fin), 64'(1'b1));
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b0;
    sel       = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i * 32'h11);

    // Reset state of both instances.
    repeat (2) tick();
    check("reset_a", 64'({o_valid, o_idx, o_data, o_last, o_busy, o_done, o_rd_addr}),
          64'({1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0}));
    sel = 1'b1;
    #1;
    check("reset_b_addr", 64'(o_rd_addr), 64'(5'd8));
    sel = 1'b0;
    reset = 1'b0;
    tick();

    // start and abort together while idle: abort wins.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_idle", 64'({o_busy, o_valid}), 64'(2'b00));
    tick();
    check("still_idle", 64'({o_busy, o_valid}), 64'(2'b00));

    // Full dump with the sink always ready.
    push_dump(0, 31);
    start_dump(0);
    drain(-1, 0, -1, -1, -1, 0);

    // Backpressure: five stalled cycles on beat 3.
    push_dump(0, 31);
    start_dump(0);
    drain(3, 5, -1, -1, -1, 0);

    // Abort together with the handshake of beat 5; no done afterwards.
    push_dump(0, 31);
    start_dump(0);
    drain(-1, 0, 5, -1, -1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_done_after_abort", 64'({o_done, o_busy}), 64'(2'b00));
    end

    // Restart from FIRST_IDX; a start re-pulsed at beat 12 is ignored.
    push_dump(0, 31);
    start_dump(0);
    drain(-1, 0, -1, 12, -1, 0);

    // Reset while beat 20 is waiting.
    push_dump(0, 31);
    start_dump(0);
    drain(-1, 0, -1, -1, 20, 0);

    // Narrow range 8..10 on the second instance.
    sel = 1'b1;
    #1;
    push_dump(8, 10);
    start_dump(8);
    drain(-1, 0, -1, -1, -1, 8);
    sel = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
